// File: rtl/ks_pkg.sv
// Shared types for the Kogge-Stone adder output stage.
package ks_pkg;

    // Default adder width.
    localparam int KS_W = 8;

    // One finished adder result as it travels through the output buffer.
    typedef struct packed {
        logic [KS_W-1:0] sum;
        logic            cout;
        logic            ovf;
        logic            zero;
    } ks_res_t;

    // Occupancy of the 2-entry output buffer.
    typedef enum logic [1:0] {
        CNT_EMPTY = 2'd0,
        CNT_ONE   = 2'd1,
        CNT_TWO   = 2'd2
    } ks_cnt_e;

endpackage

// File: rtl/ks_skid2.sv
// Generic 2-entry valid/ready buffer.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid must not depend on ready; data is only meaningful while valid.
// o_ready is decoded from registered occupancy alone, so no combinational path
// exists from i_ready to o_ready.
module ks_skid2
    import ks_pkg::*;
#(
    parameter type T     = ks_res_t,
    parameter int  DEPTH = 2
) (
    input  logic    i_clk,
    input  logic    i_rst_n,
    input  logic    i_valid,
    output logic    o_ready,
    input  T        i_data,
    output logic    o_valid,
    input  logic    i_ready,
    output T        o_data,
    output ks_cnt_e o_state
);

    if (DEPTH != 2) begin : g_depth_check
        $error("ks_skid2: DEPTH must be 2");
    end

    ks_cnt_e state_q;
    ks_cnt_e state_d;
    logic    wr_ptr_q;
    logic    rd_ptr_q;
    T        mem_q [2];
    logic    push;
    logic    pop;

    assign o_ready = (state_q != CNT_TWO);
    assign o_valid = (state_q != CNT_EMPTY);
    assign push    = i_valid && o_ready;
    assign pop     = o_valid && i_ready;
    assign o_data  = mem_q[rd_ptr_q];
    assign o_state = state_q;

    // Next occupancy from push/pop; TWO can never see a push since o_ready is low.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CNT_EMPTY: if (push) state_d = CNT_ONE;
            CNT_ONE: begin
                if (push && !pop)      state_d = CNT_TWO;
                else if (pop && !push) state_d = CNT_EMPTY;
            end
            CNT_TWO:   if (pop) state_d = CNT_ONE;
            default:   state_d = CNT_EMPTY;
        endcase
    end

    // Occupancy state and 1-bit wrapping pointers; reset discards in-flight entries.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= CNT_EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
        end
    end

    // Entry storage; cleared on reset so the head reads as all zeros.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

endmodule

// File: rtl/ks_sum_out.sv
// Output end of the Kogge-Stone adder: forms sum and flags from the resolved
// carries and saved propagates, then buffers them behind a valid/ready port.
module ks_sum_out
    import ks_pkg::*;
#(
    parameter int W     = KS_W,
    parameter int DEPTH = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic         i_c0,
    input  logic [W-1:0] i_gk,
    input  logic [W-1:0] i_p_save,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_sum,
    output logic         o_cout,
    output logic         o_ovf,
    output logic         o_zero,
    output ks_cnt_e      o_count
);

    if (W < 2) begin : g_width_check
        $error("ks_sum_out: W must be at least 2");
    end

    // Result record sized to this instance's width.
    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    logic [W-1:0] sum;
    res_t         res_in;
    res_t         res_out;

    // Carry into bit i is the carry out of bit i-1; bit 0 takes the forwarded carry-in.
    always_comb begin
        sum         = i_p_save ^ {i_gk[W-2:0], i_c0};
        res_in      = '0;
        res_in.sum  = sum;
        res_in.cout = i_gk[W-1];
        res_in.ovf  = i_gk[W-1] ^ i_gk[W-2];
        res_in.zero = ~|sum;
    end

    ks_skid2 #(
        .T     (res_t),
        .DEPTH (DEPTH)
    ) u_buf (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (res_in),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (res_out),
        .o_state (o_count)
    );

    assign o_sum  = res_out.sum;
    assign o_cout = res_out.cout;
    assign o_ovf  = res_out.ovf;
    assign o_zero = res_out.zero;

endmodule

// File: tb/tb_ks_sum_out.sv
// Directed bench for ks_sum_out with a FIFO scoreboard on the output port.
module tb_ks_sum_out;
    import ks_pkg::*;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic        i_c0;
    logic [7:0]  i_gk;
    logic [7:0]  i_p_save;
    logic        o_valid;
    logic        i_ready;
    logic [7:0]  o_sum;
    logic        o_cout;
    logic        o_ovf;
    logic        o_zero;
    ks_cnt_e     o_count;

    ks_sum_out #(.W(8), .DEPTH(2)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_c0     (i_c0),
        .i_gk     (i_gk),
        .i_p_save (i_p_save),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_sum    (o_sum),
        .o_cout   (o_cout),
        .o_ovf    (o_ovf),
        .o_zero   (o_zero),
        .o_count  (o_count)
    );

    // ---------------- clock ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ---------------- check + scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [10:0] exp_q[$];
    logic [10:0] cur_exp;
    logic [10:0] obs;

    assign obs = {o_sum, o_cout, o_ovf, o_zero};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Sample between edges: record accepted pushes, compare every pop in order.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) check("pop_unexpected", 32'(obs), 32'h7ff);
                else                   check("pop_order", 32'(obs), 32'(exp_q.pop_front()));
            end
            if (i_valid && o_ready) exp_q.push_back(cur_exp);
        end
    end

    // ---------------- vectors {p_save, gk, c0, {sum,cout,ovf,zero}} ----------------
    typedef struct {
        logic [7:0]  p;
        logic [7:0]  gk;
        logic        c0;
        logic [10:0] exp;
    } vec_t;
    vec_t vt [7];

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_vec(input int k);
        i_p_save = vt[k].p;
        i_gk     = vt[k].gk;
        i_c0     = vt[k].c0;
        cur_exp  = vt[k].exp;
    endtask

    task automatic run_single(input int k);
        set_vec(k);
        i_valid = 1'b1;
        i_ready = 1'b0;
        check("single_ready", 32'(o_ready), 32'd1);
        tick();
        i_valid = 1'b0;
        check("single_valid", 32'(o_valid), 32'd1);
        check("single_res", 32'(obs), 32'(vt[k].exp));
        check("single_cnt", 32'(o_count), 32'd1);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check("single_drain", 32'(o_valid), 32'd0);
    endtask

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{8'h0E, 8'h0F, 1'b0, {8'h10, 1'b0, 1'b0, 1'b0}};
        vt[1] = '{8'hFE, 8'hFF, 1'b0, {8'h00, 1'b1, 1'b0, 1'b1}};
        vt[2] = '{8'h7E, 8'h7F, 1'b0, {8'h80, 1'b0, 1'b1, 1'b0}};
        vt[3] = '{8'h00, 8'h00, 1'b1, {8'h01, 1'b0, 1'b0, 1'b0}};
        vt[4] = '{8'hFF, 8'hFF, 1'b1, {8'h00, 1'b1, 1'b0, 1'b1}};
        vt[5] = '{8'h00, 8'hFF, 1'b0, {8'hFE, 1'b1, 1'b0, 1'b0}};
        vt[6] = '{8'h00, 8'h80, 1'b0, {8'h00, 1'b1, 1'b1, 1'b1}};

        i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_p_save = '0; i_gk = '0; i_c0 = 1'b0; cur_exp = '0;
        #3;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_res", 32'(obs), 32'd0);
        check("rst_cnt", 32'(o_count), 32'd0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();
        check("rst_ready", 32'(o_ready), 32'd1);

        // single results, including the three reference additions
        for (int k = 0; k < 7; k++) run_single(k);

        // back-pressure: three pushes while stalled, then drain in order
        i_ready = 1'b0;
        set_vec(0); i_valid = 1'b1;
        tick();
        set_vec(1);
        check("bp_ready_one", 32'(o_ready), 32'd1);
        tick();
        set_vec(2);
        check("bp_ready_full", 32'(o_ready), 32'd0);
        check("bp_cnt_two", 32'(o_count), 32'd2);
        tick();
        check("bp_hold_cnt", 32'(o_count), 32'd2);
        check("bp_hold_head", 32'(obs), 32'(vt[0].exp));
        i_ready = 1'b1;
        tick();
        check("bp_after_pop1", 32'(obs), 32'(vt[1].exp));
        check("bp_cnt_one", 32'(o_count), 32'd1);
        tick();
        i_valid = 1'b0;
        check("bp_third_head", 32'(obs), 32'(vt[2].exp));
        check("bp_cnt_still_one", 32'(o_count), 32'd1);
        tick();
        i_ready = 1'b0;
        check("bp_empty", 32'(o_valid), 32'd0);
        check("bp_q_empty", 32'(exp_q.size()), 32'd0);

        // push and pop in the same cycle while holding one entry
        set_vec(6); i_valid = 1'b1; i_ready = 1'b0;
        tick();
        set_vec(3); i_ready = 1'b1;
        check("pp_head_old", 32'(obs), 32'(vt[6].exp));
        tick();
        i_valid = 1'b0;
        check("pp_cnt", 32'(o_count), 32'd1);
        check("pp_head_new", 32'(obs), 32'(vt[3].exp));
        tick();
        i_ready = 1'b0;
        check("pp_drained", 32'(o_valid), 32'd0);

        // reset with two entries buffered
        set_vec(5); i_valid = 1'b1;
        tick();
        set_vec(2);
        tick();
        i_valid = 1'b0;
        check("rst2_cnt_two", 32'(o_count), 32'd2);
        #2;
        i_rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("rst2_valid", 32'(o_valid), 32'd0);
        check("rst2_res", 32'(obs), 32'd0);
        check("rst2_cnt", 32'(o_count), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();
        check("rst2_ready", 32'(o_ready), 32'd1);
        check("rst2_valid_after", 32'(o_valid), 32'd0);

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
